mem_port_arbiter4: RTL and testbench

Round-robin arbiter and sequencer that shares a single memory/bus port between four requesters (e.g. IF, MEM, debug, DMA) in the pipelined CPU. It owns the 2-bit select that drives the 32-bit `yMux4to1` steering requester address/write-data onto the shared port. It runs the port's valid/ready handshake, returns read data with a per-requester done pulse, and aborts stalled transactions with a watchdog.

---
 rtl/mem_port_arbiter4.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter4.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter/sequencer sharing one valid/ready memory port between four requesters,
// with per-requester done pulses, registered read data and a watchdog abort.
module mem_port_arbiter4 #(
   parameter int unsigned W     = 32,
   parameter int unsigned TMO_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     req,
   input  logic [3:0]     we,
   input  logic [4*W-1:0] addr_flat,
   input  logic [4*W-1:0] wdata_flat,
   output logic [3:0]     gnt,
   output logic [3:0]     done,
   output logic           err,
   output logic [W-1:0]   rdata,
   output logic [1:0]     sel,
   output logic           busy,
   output logic           mem_valid,
   output logic           mem_we,
   output logic [W-1:0]   mem_addr,
   output logic [W-1:0]   mem_wdata,
   input  logic           mem_ready,
   input  logic [W-1:0]   mem_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   // Last watchdog value before expiry: ISSUE lasts at most 2^TMO_W-1 cycles.
   localparam logic [TMO_W-1:0] WdogLast = {{(TMO_W-1){1'b1}}, 1'b0};

   state_e           state_q;
   logic [1:0]       ptr_q;
   logic [TMO_W-1:0] wdog_q;
   logic [1:0]       pick;
   logic [1:0]       idx;
   logic             found;

   // First requesting index at or above ptr, wrapping modulo 4.
   always_comb begin
      pick  = ptr_q;
      idx   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= 2'd0;
         sel       <= 2'd0;
         wdog_q    <= '0;
         gnt       <= 4'b0000;
         done      <= 4'b0000;
         err       <= 1'b0;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_valid <= 1'b0;
      end else begin
         done <= 4'b0000;
         err  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (found) begin
                  sel       <= pick;
                  gnt       <= 4'b0001 << pick;
                  wdog_q    <= '0;
                  busy      <= 1'b1;
                  mem_valid <= 1'b1;
                  state_q   <= StIssue;
               end
            end
            StIssue: begin
               if (mem_ready) begin
                  rdata     <= mem_rdata;
                  done      <= 4'b0001 << sel;
                  mem_valid <= 1'b0;
                  state_q   <= StResp;
               end else if (wdog_q == WdogLast) begin
                  // Timed out: complete with err and leave rdata untouched.
                  err       <= 1'b1;
                  done      <= 4'b0001 << sel;
                  mem_valid <= 1'b0;
                  state_q   <= StResp;
               end else begin
                  wdog_q <= wdog_q + TMO_W'(1);
               end
            end
            StResp: begin
               ptr_q   <= sel + 2'd1;
               gnt     <= 4'b0000;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q   <= StIdle;
               gnt       <= 4'b0000;
               busy      <= 1'b0;
               mem_valid <= 1'b0;
            end
         endcase
      end
   end

   // 4:1 steering of the granted requester onto the shared port.
   always_comb begin
      mem_we    = we[0];
      mem_addr  = addr_flat[0 +: W];
      mem_wdata = wdata_flat[0 +: W];
      unique case (sel)
         2'd0: begin
            mem_we    = we[0];
            mem_addr  = addr_flat[0 +: W];
            mem_wdata = wdata_flat[0 +: W];
         end
         2'd1: begin
            mem_we    = we[1];
            mem_addr  = addr_flat[W +: W];
            mem_wdata = wdata_flat[W +: W];
         end
         2'd2: begin
            mem_we    = we[2];
            mem_addr  = addr_flat[2*W +: W];
            mem_wdata = wdata_flat[2*W +: W];
         end
         2'd3: begin
            mem_we    = we[3];
            mem_addr  = addr_flat[3*W +: W];
            mem_wdata = wdata_flat[3*W +: W];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Bench for mem_port_arbiter4: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_mem_port_arbiter4;

   localparam int unsigned W     = 32;
   localparam int unsigned TMO_W = 4;
   localparam int          TMO   = (1 << TMO_W) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     req = '0;
   logic [3:0]     we = '0;
   logic [4*W-1:0] addr_flat = '0;
   logic [4*W-1:0] wdata_flat = '0;
   logic [3:0]     gnt;
   logic [3:0]     done;
   logic           err;
   logic [W-1:0]   rdata;
   logic [1:0]     sel;
   logic           busy;
   logic           mem_valid;
   logic           mem_we;
   logic [W-1:0]   mem_addr;
   logic [W-1:0]   mem_wdata;
   logic           mem_ready = 1'b0;
   logic [W-1:0]   mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter4 #(.W(W), .TMO_W(TMO_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .we         (we),
      .addr_flat  (addr_flat),
      .wdata_flat (wdata_flat),
      .gnt        (gnt),
      .done       (done),
      .err        (err),
      .rdata      (rdata),
      .sel        (sel),
      .busy       (busy),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: 0 = no owner, 1 = owner waiting on port, 2 = owner reporting.
   int           m_phase = 0;
   int           m_owner = 0;
   int           m_ptr = 0;
   int           m_waited = 0;
   bit           m_err = 0;
   logic [W-1:0] m_rdata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_owner = 0; m_ptr = 0; m_waited = 0; m_err = 0; m_rdata = '0;
      end else begin
         case (m_phase)
            0: if (req != 0) begin
               for (int k = 0; k < 4; k++) begin
                  if (req[(m_ptr + k) % 4]) begin
                     m_owner = (m_ptr + k) % 4;
                     break;
                  end
               end
               m_waited = 0;
               m_phase  = 1;
            end
            1: if (mem_ready) begin
               m_rdata = mem_rdata;
               m_err   = 0;
               m_phase = 2;
            end else begin
               m_waited++;
               if (m_waited == TMO) begin
                  m_err   = 1;
                  m_phase = 2;
               end
            end
            default: begin
               m_ptr   = (m_owner + 1) % 4;
               m_err   = 0;
               m_phase = 0;
            end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      check("gnt", gnt, (m_phase != 0) ? (4'b0001 << m_owner) : 4'b0000);
      check("done", done, (m_phase == 2) ? (4'b0001 << m_owner) : 4'b0000);
      check("err", err, (m_phase == 2) && m_err);
      check("sel", sel, m_owner[1:0]);
      check("rdata", rdata, m_rdata);
      check("busy", busy, m_phase != 0);
      check("mem_valid", mem_valid, m_phase == 1);
      if (m_phase == 1) begin
         check("mem_we", mem_we, we[m_owner]);
         check("mem_addr", mem_addr, addr_flat[m_owner*W +: W]);
         check("mem_wdata", mem_wdata, wdata_flat[m_owner*W +: W]);
      end
   end

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   int order[5];
   int n;
   int nv;
   bit got;
   bit stall = 0;

   initial begin
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 4'b0000);
      check("rst_sel", sel, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", mem_valid, 1'b0);
      check("rst_done", done, 4'b0000);
      check("rst_rdata", rdata, 32'h0);
      rst_n = 1'b1;

      // Single read from requester 2.
      req = 4'b0100; we = 4'b0000; addr_flat[2*W +: W] = 32'h1000;
      @(negedge clk);
      check("rd_gnt", gnt, 4'b0100);
      check("rd_sel", sel, 2'd2);
      check("rd_valid", mem_valid, 1'b1);
      check("rd_addr", mem_addr, 32'h1000);
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      check("rd_done", done, 4'b0100);
      check("rd_rdata", rdata, 32'hDEADBEEF);
      check("rd_err", err, 1'b0);
      mem_ready = 1'b0; req = 4'b0000;
      @(negedge clk);
      check("rd_idle", busy, 1'b0);

      // Round-robin with everyone requesting and a zero-wait port.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; req = 4'b1111; mem_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         @(negedge clk);
         if (busy) check("rr_onehot", $onehot(gnt), 1'b1);
         if (done != 0) begin
            order[n] = idx_of(done);
            n++;
            if (n == 5) req = 4'b0000;
         end
      end
      check("rr_count", n, 5);
      check("rr_0", order[0], 0);
      check("rr_1", order[1], 1);
      check("rr_2", order[2], 2);
      check("rr_3", order[3], 3);
      check("rr_4", order[4], 0);
      mem_ready = 1'b0; req = 4'b0000;
      @(negedge clk);

      // Write from requester 3 with a three-cycle stall.
      req = 4'b1000; we = 4'b1000; wdata_flat[3*W +: W] = 32'hCAFEF00D;
      nv = 0; got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (mem_valid) begin
            nv++;
            req = 4'b0000;
            check("wr_we", mem_we, 1'b1);
            check("wr_wdata", mem_wdata, 32'hCAFEF00D);
            if (nv == 4) mem_ready = 1'b1;
         end else if (done != 0) begin
            check("wr_done", done, 4'b1000);
            got = 1;
         end
      end
      check("wr_got_done", got, 1'b1);
      check("wr_valid_cycles", nv, 4);
      mem_ready = 1'b0; we = 4'b0000;

      // Timeout on requester 0; requester 1 then wins.
      req = 4'b0001;
      nv = 0; got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (mem_valid) nv++;
         else if (done != 0) begin
            check("to_done", done, 4'b0001);
            check("to_err", err, 1'b1);
            req = 4'b0011;
            got = 1;
         end
      end
      check("to_got_done", got, 1'b1);
      check("to_valid_cycles", nv, 15);
      @(negedge clk);
      @(negedge clk);
      check("to_next_gnt", gnt, 4'b0010);
      mem_ready = 1'b1; req = 4'b0000;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);

      // Asynchronous reset while in ISSUE.
      req = 4'b0100;
      @(negedge clk);
      check("mr_valid", mem_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_gnt", gnt, 4'b0000);
      check("mr_busy", busy, 1'b0);
      check("mr_valid0", mem_valid, 1'b0);
      check("mr_done", done, 4'b0000);
      check("mr_sel", sel, 2'd0);
      @(negedge clk);
      rst_n = 1'b1; req = 4'b0110;
      @(negedge clk);
      check("mr_first_gnt", gnt, 4'b0010);
      mem_ready = 1'b1; req = 4'b0000;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);

      // Stray ready while idle, then a withdrawn request that still completes.
      mem_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stray_done", done, 4'b0000);
         check("stray_busy", busy, 1'b0);
      end
      mem_ready = 1'b0; req = 4'b0001;
      @(negedge clk);
      req = 4'b0000;
      repeat (2) @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      check("wd_done", done, 4'b0001);
      check("wd_err", err, 1'b0);
      mem_ready = 1'b0;

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (m_phase == 0) begin
            we = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
               addr_flat[i*W +: W]  = $urandom;
               wdata_flat[i*W +: W] = $urandom;
            end
            req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            stall = ($urandom_range(0, 9) == 0);
         end
         mem_ready = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
